// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master drives the byte stream; slave is the loader itself.
interface instr_mem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  im_we;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic [31:0]           im_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  im_we,
    input  im_addr,
    input  im_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output im_we,
    output im_addr,
    output im_wdata
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time loader: framed byte stream -> instruction memory words,
// holding the CPU in reset until a checksum-verified image is in place.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instr_mem_loader_if.slave     bus,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

  state_t                state_q;
  logic [7:0]            len_lo_q;
  logic [15:0]           len_q;
  logic [7:0]            chk_q;
  logic [1:0]            bidx_q;
  logic [23:0]           wbuf_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  cpu_rst_q;
  logic                  done_q;
  logic                  err_q;

  logic                  busy_w;
  logic                  xfer;
  logic [15:0]           len_d;
  logic                  len_bad;
  logic [7:0]            chk_d;
  logic [31:0]           word_d;
  logic [ADDR_WIDTH:0]   cnt_d;
  logic                  last_d;

  // Ready is a pure state decode so no input can reach it combinationally.
  always_comb begin
    busy_w = 1'b0;
    unique case (state_q)
      S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: busy_w = 1'b1;
      default:                             busy_w = 1'b0;
    endcase
  end

  always_comb begin
    xfer    = bus.in_valid && busy_w;
    len_d   = {bus.in_data, len_lo_q};
    len_bad = (len_d == 16'd0) || ({1'b0, len_d} > CAP);
    chk_d   = chk_q ^ bus.in_data;
    word_d  = {bus.in_data, wbuf_q};
    cnt_d   = cnt_q + (ADDR_WIDTH+1)'(1);
    last_d  = 17'(cnt_d) == {1'b0, len_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_lo_q  <= '0;
      len_q     <= '0;
      chk_q     <= '0;
      bidx_q    <= '0;
      wbuf_q    <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q   <= S_LEN_LO;
            chk_q     <= '0;
            bidx_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_lo_q <= bus.in_data;
            chk_q    <= chk_d;
            state_q  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_q <= len_d;
            chk_q <= chk_d;
            if (len_bad) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            chk_q  <= chk_d;
            bidx_q <= bidx_q + 2'd1;
            // Bytes shift in from the top, so byte k lands at [8k+7:8k].
            wbuf_q <= word_d[31:8];
            if (bidx_q == 2'd3) begin
              we_q    <= 1'b1;
              addr_q  <= cnt_q[ADDR_WIDTH-1:0];
              wdata_q <= word_d;
              cnt_q   <= cnt_d;
              if (last_d) begin
                state_q <= S_CHECK;
              end
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (bus.in_data == chk_q) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              cpu_rst_q <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = busy_w;
  assign bus.im_we    = we_q;
  assign bus.im_addr  = addr_q;
  assign bus.im_wdata = wdata_q;
  assign busy         = busy_w;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign error        = err_q;
  assign word_count   = cnt_q;

endmodule
